// File: rtl/rst_pkg.sv
// Shared types for the reset sequencer: FSM states and reset-cause encoding.
package rst_pkg;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_HOLD,
    ST_WAIT_LOCK,
    ST_REL,
    ST_RUN
  } state_t;

  localparam int CAUSE_SW   = 0;
  localparam int CAUSE_EXT  = 1;
  localparam int CAUSE_LOCK = 2;

  typedef logic [2:0] cause_t;

endpackage

// File: rtl/rst_seq_sync2.sv
// Generic two-flop synchronizer; P_RST is the value both flops take while in reset.
module sync2 #(
  parameter logic P_RST = 1'b0
) (
  input  logic i_clk,
  input  logic i_arst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      meta_q <= P_RST;
      sync_q <= P_RST;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: merges pushbutton, software and lock-loss resets, stretches the
// event, waits for PLL lock, then releases the outputs in index order.
module rst_seq
  import rst_pkg::*;
#(
  parameter int P_NOUT = 3,
  parameter int P_HOLD = 16,
  parameter int P_GAP  = 8,
  parameter int P_DBW  = 4
) (
  input  logic              i_clk,
  input  logic              i_arst,
  input  logic              i_ext_rst_n,
  input  logic              i_pll_lock,
  input  logic              i_sw_rst,
  output logic [P_NOUT-1:0] o_rst,
  output logic              o_ready,
  output logic [2:0]        o_cause
);

  localparam int CNT_MAX = (P_HOLD > P_GAP) ? P_HOLD : P_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DB_W    = $clog2(P_DBW + 1);
  localparam int IDX_W   = (P_NOUT > 1) ? $clog2(P_NOUT) : 1;

  logic              ext_s;
  logic              lock_s;
  logic [DB_W-1:0]   dbc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic [IDX_W-1:0]  idx_q;
  state_t            state_q;
  logic [P_NOUT-1:0] rst_q;
  logic              ready_q;
  cause_t            cause_q;
  cause_t            src;
  logic              ext_req;
  logic              req;

  // Pushbutton idles high, so its synchronizer resets to "not pressed"; lock resets to "unlocked".
  sync2 #(.P_RST(1'b1)) u_sync_ext (
    .i_clk (i_clk),
    .i_arst(i_arst),
    .d_i   (i_ext_rst_n),
    .q_o   (ext_s)
  );

  sync2 #(.P_RST(1'b0)) u_sync_lock (
    .i_clk (i_clk),
    .i_arst(i_arst),
    .d_i   (i_pll_lock),
    .q_o   (lock_s)
  );

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      dbc_q <= '0;
    end else if (ext_s) begin
      dbc_q <= '0;
    end else if (dbc_q != DB_W'(P_DBW)) begin
      dbc_q <= dbc_q + DB_W'(1);
    end
  end

  assign ext_req = !ext_s && (dbc_q == DB_W'(P_DBW));

  always_comb begin
    src             = '0;
    src[CAUSE_SW]   = i_sw_rst;
    src[CAUSE_EXT]  = ext_req;
    src[CAUSE_LOCK] = !lock_s && ((state_q == ST_REL) || (state_q == ST_RUN));
  end

  assign req     = |src;
  assign cnt_inc = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      cause_q <= '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          state_q <= ST_HOLD;
          cnt_q   <= '0;
        end
        ST_HOLD: begin
          if (req) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_W'(P_HOLD - 1)) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        ST_WAIT_LOCK: begin
          if (req) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
          end else if (lock_s) begin
            state_q <= ST_REL;
            rst_q   <= rst_q << 1;
            idx_q   <= '0;
            cnt_q   <= '0;
          end
        end
        ST_REL, ST_RUN: begin
          // A new event only begins from REL/RUN, so this is the one place cause is captured.
          if (req) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            cause_q <= src;
          end else if (state_q == ST_REL) begin
            if (cnt_q == CNT_W'(P_GAP - 1)) begin
              cnt_q <= '0;
              if (idx_q == IDX_W'(P_NOUT - 1)) begin
                state_q <= ST_RUN;
                ready_q <= 1'b1;
              end else begin
                rst_q <= rst_q << 1;
                idx_q <= idx_q + IDX_W'(1);
              end
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        default: state_q <= ST_RESET;
      endcase
    end
  end

  assign o_rst   = rst_q;
  assign o_ready = ready_q;
  assign o_cause = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with default parameters; edge numbers are hand-derived.
module tb_rst_seq;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       ext_n = 1'b1;
  logic       lock = 1'b1;
  logic       sw = 1'b0;
  logic [2:0] o_rst;
  logic       o_ready;
  logic [2:0] o_cause;

  int checks = 0;
  int failures = 0;

  rst_seq dut (
    .i_clk      (clk),
    .i_arst     (arst),
    .i_ext_rst_n(ext_n),
    .i_pll_lock (lock),
    .i_sw_rst   (sw),
    .o_rst      (o_rst),
    .o_ready    (o_ready),
    .o_cause    (o_cause)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edge index (1 = next rising edge) at which each output released and ready rose; -1 if never.
  task automatic measure(input int budget, output int e0, output int e1, output int e2, output int er);
    e0 = -1; e1 = -1; e2 = -1; er = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (e0 < 0 && o_rst[0] == 1'b0) e0 = i;
      if (e1 < 0 && o_rst[1] == 1'b0) e1 = i;
      if (e2 < 0 && o_rst[2] == 1'b0) e2 = i;
      if (er < 0 && o_ready == 1'b1) begin
        er = i;
        break;
      end
    end
  endtask

  task automatic wait_assert(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (o_rst == 3'b111) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int e0, e1, e2, er;
    arst = 1'b1; ext_n = 1'b1; lock = 1'b1; sw = 1'b0;
    repeat (3) tick();
    checks++; if (o_rst !== 3'b111) begin failures++; $display("FAIL reset_rst got=%b exp=111", o_rst); end
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", o_ready); end
    checks++; if (o_cause !== 3'b000) begin failures++; $display("FAIL reset_cause got=%b exp=000", o_cause); end
    @(negedge clk) arst = 1'b0;
    measure(60, e0, e1, e2, er);
    $display("power-on release edges %0d %0d %0d ready %0d", e0, e1, e2, er);
    checks++; if (e0 != 18) begin failures++; $display("FAIL po_rel0 got=%0d exp=18", e0); end
    checks++; if (e1 != 26) begin failures++; $display("FAIL po_rel1 got=%0d exp=26", e1); end
    checks++; if (e2 != 34) begin failures++; $display("FAIL po_rel2 got=%0d exp=34", e2); end
    checks++; if (er != 42) begin failures++; $display("FAIL po_ready got=%0d exp=42", er); end
    checks++; if (o_cause !== 3'b000) begin failures++; $display("FAIL po_cause got=%b exp=000", o_cause); end
  endtask

  task automatic test_lock_late();
    int e0, e1, e2, er;
    @(negedge clk) begin arst = 1'b1; lock = 1'b0; end
    @(negedge clk) arst = 1'b0;
    repeat (100) tick();
    checks++; if (o_rst !== 3'b111 || o_ready !== 1'b0) begin
      failures++; $display("FAIL nolock_hold got rst=%b ready=%b exp rst=111 ready=0", o_rst, o_ready);
    end
    lock = 1'b1;
    measure(60, e0, e1, e2, er);
    $display("late-lock release edges %0d %0d %0d ready %0d", e0, e1, e2, er);
    checks++; if (e0 != 3) begin failures++; $display("FAIL late_rel0 got=%0d exp=3", e0); end
    checks++; if (e1 != 11) begin failures++; $display("FAIL late_rel1 got=%0d exp=11", e1); end
    checks++; if (e2 != 19) begin failures++; $display("FAIL late_rel2 got=%0d exp=19", e2); end
    checks++; if (er != 27) begin failures++; $display("FAIL late_ready got=%0d exp=27", er); end
  endtask

  task automatic test_sw_rst();
    int e0, e1, e2, er;
    @(negedge clk) sw = 1'b1;
    tick();
    sw = 1'b0;
    $display("sw pulse -> rst=%b ready=%b cause=%b", o_rst, o_ready, o_cause);
    checks++; if (o_rst !== 3'b111) begin failures++; $display("FAIL sw_rst got=%b exp=111", o_rst); end
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL sw_ready got=%b exp=0", o_ready); end
    checks++; if (o_cause !== 3'b001) begin failures++; $display("FAIL sw_cause got=%b exp=001", o_cause); end
    measure(60, e0, e1, e2, er);
    $display("sw re-release edges %0d %0d %0d ready %0d", e0, e1, e2, er);
    checks++; if (e0 != 17) begin failures++; $display("FAIL sw_rel0 got=%0d exp=17", e0); end
    checks++; if (e1 != 25) begin failures++; $display("FAIL sw_rel1 got=%0d exp=25", e1); end
    checks++; if (e2 != 33) begin failures++; $display("FAIL sw_rel2 got=%0d exp=33", e2); end
    checks++; if (er != 41) begin failures++; $display("FAIL sw_ready_edge got=%0d exp=41", er); end
  endtask

  task automatic test_ext();
    int n, e0, e1, e2, er;
    ext_n = 1'b0;
    repeat (3) tick();
    ext_n = 1'b1;
    repeat (10) tick();
    $display("ext glitch -> rst=%b ready=%b cause=%b", o_rst, o_ready, o_cause);
    checks++; if (o_rst !== 3'b000 || o_ready !== 1'b1) begin
      failures++; $display("FAIL ext_glitch got rst=%b ready=%b exp rst=000 ready=1", o_rst, o_ready);
    end
    checks++; if (o_cause !== 3'b001) begin failures++; $display("FAIL ext_glitch_cause got=%b exp=001", o_cause); end
    ext_n = 1'b0;
    wait_assert(15, n);
    $display("ext press -> asserted at edge %0d cause=%b", n, o_cause);
    checks++; if (n != 7) begin failures++; $display("FAIL ext_latency got=%0d exp=7", n); end
    checks++; if (o_cause !== 3'b010) begin failures++; $display("FAIL ext_cause got=%b exp=010", o_cause); end
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL ext_ready got=%b exp=0", o_ready); end
    repeat (40 - ((n > 0) ? n : 0)) tick();
    ext_n = 1'b1;
    measure(70, e0, e1, e2, er);
    $display("ext release edges %0d %0d %0d ready %0d", e0, e1, e2, er);
    checks++; if (e0 != 19) begin failures++; $display("FAIL ext_rel0 got=%0d exp=19", e0); end
    checks++; if (e1 != 27) begin failures++; $display("FAIL ext_rel1 got=%0d exp=27", e1); end
    checks++; if (e2 != 35) begin failures++; $display("FAIL ext_rel2 got=%0d exp=35", e2); end
    checks++; if (er != 43) begin failures++; $display("FAIL ext_ready_edge got=%0d exp=43", er); end
  endtask

  task automatic test_lock_loss();
    int n, e0, e1, e2, er;
    @(negedge clk) arst = 1'b1;
    @(negedge clk) arst = 1'b0;
    repeat (27) tick();
    checks++; if (o_rst !== 3'b100) begin failures++; $display("FAIL ll_pre got=%b exp=100", o_rst); end
    lock = 1'b0;
    wait_assert(10, n);
    $display("lock loss -> asserted at edge %0d cause=%b", n, o_cause);
    checks++; if (n != 3) begin failures++; $display("FAIL ll_latency got=%0d exp=3", n); end
    checks++; if (o_cause !== 3'b100) begin failures++; $display("FAIL ll_cause got=%b exp=100", o_cause); end
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL ll_ready got=%b exp=0", o_ready); end
    repeat (50) tick();
    checks++; if (o_rst !== 3'b111) begin failures++; $display("FAIL ll_wait got=%b exp=111", o_rst); end
    lock = 1'b1;
    measure(60, e0, e1, e2, er);
    $display("relock release edges %0d %0d %0d ready %0d", e0, e1, e2, er);
    checks++; if (e0 != 3) begin failures++; $display("FAIL ll_rel0 got=%0d exp=3", e0); end
    checks++; if (e1 != 11) begin failures++; $display("FAIL ll_rel1 got=%0d exp=11", e1); end
    checks++; if (e2 != 19) begin failures++; $display("FAIL ll_rel2 got=%0d exp=19", e2); end
    checks++; if (er != 27) begin failures++; $display("FAIL ll_ready_edge got=%0d exp=27", er); end
    checks++; if (o_cause !== 3'b100) begin failures++; $display("FAIL ll_cause_hold got=%b exp=100", o_cause); end
  endtask

  task automatic test_arst_mid();
    int e0, e1, e2, er;
    @(negedge clk) sw = 1'b1;
    tick();
    sw = 1'b0;
    checks++; if (o_cause !== 3'b001) begin failures++; $display("FAIL am_cause_pre got=%b exp=001", o_cause); end
    repeat (25) tick();
    checks++; if (o_rst !== 3'b100) begin failures++; $display("FAIL am_midrel got=%b exp=100", o_rst); end
    #2 arst = 1'b1;
    #1;
    $display("async reset mid-REL -> rst=%b ready=%b cause=%b", o_rst, o_ready, o_cause);
    checks++; if (o_rst !== 3'b111) begin failures++; $display("FAIL am_rst got=%b exp=111", o_rst); end
    checks++; if (o_cause !== 3'b000) begin failures++; $display("FAIL am_cause got=%b exp=000", o_cause); end
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL am_ready got=%b exp=0", o_ready); end
    @(negedge clk) arst = 1'b0;
    measure(60, e0, e1, e2, er);
    $display("post-reset release edges %0d %0d %0d ready %0d", e0, e1, e2, er);
    checks++; if (e0 != 18) begin failures++; $display("FAIL am_rel0 got=%0d exp=18", e0); end
    checks++; if (e1 != 26) begin failures++; $display("FAIL am_rel1 got=%0d exp=26", e1); end
    checks++; if (e2 != 34) begin failures++; $display("FAIL am_rel2 got=%0d exp=34", e2); end
    checks++; if (er != 42) begin failures++; $display("FAIL am_ready_edge got=%0d exp=42", er); end
  endtask

  initial begin
    test_reset();
    test_lock_late();
    test_sw_rst();
    test_ext();
    test_lock_loss();
    test_arst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
# rst_seq

Reset sequencer: the source side of the per-domain reset synchronizers. It merges the external pushbutton, software reset request and PLL lock loss into one reset event. It stretches that event to a minimum width and waits for PLL lock. It then releases `P_NOUT` reset outputs one at a time, in index order, with a fixed gap between each. Its outputs feed the per-domain synchronizers as their asynchronous reset inputs.

## Interface
Parameters:
- `P_NOUT`, 3, number of sequenced reset outputs (1..8)
- `P_HOLD`, 16, minimum assert cycles after the last active source
- `P_GAP`, 8, cycles between consecutive releases
- `P_DBW`, 4, debounce length for `i_ext_rst_n`, in consecutive cycles

Ports:
- `i_clk`  in  1  clock
- `i_arst`  in  1  reset, asynchronous, active-high
- `i_ext_rst_n`  in  1  pushbutton reset; asynchronous to `i_clk`, active-low
- `i_pll_lock`  in  1  PLL lock; asynchronous to `i_clk`
- `i_sw_rst`  in  1  software reset request; single-cycle pulse, synchronous to `i_clk`
- `o_rst`  out  `P_NOUT`  reset outputs, active-high, registered
- `o_ready`  out  1  high once every output is released
- `o_cause`  out  3  cause of the last reset event: bit0 sw, bit1 ext, bit2 lock loss; 3'b000 means power-on

## Operation
- `i_ext_rst_n` and `i_pll_lock` each pass through a 2-flop synchronizer; call the results `ext_s` and `lock_s`.
- `ext_req` is asserted once `ext_s` has been low for `P_DBW` consecutive cycles. It deasserts on the first cycle `ext_s` is high.
- `req` = `i_sw_rst` | `ext_req` | (!`lock_s` while in REL or RUN).
- States:
  - RESET: entered only via `i_arst`. Moves to HOLD on the first edge.
  - HOLD: the counter counts `P_HOLD` cycles. Any `req` clears the counter. Expiry moves to WAIT_LOCK.
  - WAIT_LOCK: waits for `lock_s`=1, then deasserts `o_rst[0]` and moves to REL with index 0.
  - REL: every `P_GAP` cycles, deasserts the next `o_rst[i]`. `P_GAP` cycles after `o_rst[P_NOUT-1]` is deasserted, moves to RUN.
  - RUN: `o_ready`=1.
- `req` in REL or RUN: on the next edge all `o_rst` go to 1, `o_ready` goes to 0, and the state moves to HOLD with the counter cleared.
- `o_cause` captures the OR of the active sources on the edge a reset event begins. It holds until the next event.
- Sources that arrive while already in HOLD or WAIT_LOCK only restart the HOLD counter; they do not update `o_cause`.
- Lock loss during HOLD or WAIT_LOCK is not a new event; the sequencer simply waits.
- `o_rst` is monotonic during release: bit i is never deasserted before bit i-1.
- The HOLD counter must be sized for the larger of `P_HOLD` and `P_GAP`; it saturates and never wraps.

## Timing
- While `i_arst`=1: `o_rst` = all ones, `o_ready`=0, `o_cause`=3'b000, state RESET, counters and debounce at 0, sync flops at their reset value.
- Edge 1 is the first rising edge with `i_arst` low. With `lock_s` already 1 and no sources active:
  - HOLD occupies edges 2–17.
  - `o_rst[0]` falls on edge `P_HOLD`+2 (18).
  - `o_rst[i]` falls on edge 18+i·`P_GAP`.
  - `o_ready` rises on edge 18+`P_NOUT`·`P_GAP` (42).
- `i_sw_rst` sampled high in RUN: `o_rst` is all ones on the next edge (1-cycle latency).
- `i_ext_rst_n` falling edge: `o_rst` is all ones within 2+`P_DBW`+1 edges. Glitches shorter than `P_DBW` cycles have no effect.
- Lock loss in RUN: `o_rst` asserts 3 edges after `i_pll_lock` falls.
- Simultaneous `i_sw_rst` and `ext_req` set both `o_cause` bits.
- `i_arst` mid-sequence returns immediately (asynchronously) to the reset values.

## Structure
- Package `rst_pkg`: state enum (`ST_RESET`, `ST_HOLD`, `ST_WAIT_LOCK`, `ST_REL`, `ST_RUN`), cause bit index constants, and the 3-bit cause typedef.
- Sub-module `sync2`: generic 2-flop synchronizer with asynchronous active-high reset and a reset-value parameter. It is instantiated twice (ext, lock).
- Debounce counter, HOLD/GAP counter, release index and FSM all live in `rst_seq`.

## Test plan
- Power-on with defaults and lock high: `o_rst`=3'b111, then `o_rst[0]`, `[1]`, `[2]` fall on edges 18, 26, 34; `o_ready` rises on edge 42; `o_cause`=000.
- Lock held low for 100 cycles after reset, then raised: `o_rst[0]` falls 3 edges after the rise; the remaining releases keep the 8-cycle spacing.
- `i_sw_rst` pulse in RUN: next edge `o_rst`=111, `o_ready`=0, `o_cause`=001; a full re-release follows the same spacing.
- `i_ext_rst_n` low 3 cycles: no effect. `i_ext_rst_n` low 40 cycles: `o_rst`=111, `o_cause`=010; HOLD expires 16 cycles after `ext_s` returns high.
- `i_pll_lock` drops after `o_rst[1]` is released: all outputs reassert, `o_cause`=100, and release restarts only after lock returns.
- `i_arst` asserted mid-REL: `o_rst`=111 immediately and `o_cause`=000; the full power-on timing is repeated.
